// File: rtl/mdu_seq_ctrl_if.sv
// EX-stage <-> MDU signal bundle: operation request, HI/LO readout and the Busy stall indication.
// The EX side drives Start/MDU_Op/A/B/Req_Cancel/MDU_Out_Sel; the MDU returns MDU_Out/Busy/HI/LO.
interface mdu_seq_ctrl_if;
    logic        Start;
    logic [2:0]  MDU_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req_Cancel;
    logic        MDU_Out_Sel;
    logic [31:0] MDU_Out;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Request handshake: an op is taken on a rising edge when Start=1, Req_Cancel=0 and Busy=0;
    // there is no ready back-pressure, the stall unit holds Start low while Busy is high.
    modport master (
        output Start, MDU_Op, A, B, Req_Cancel, MDU_Out_Sel,
        input  MDU_Out, Busy, HI, LO
    );

    modport slave (
        input  Start, MDU_Op, A, B, Req_Cancel, MDU_Out_Sel,
        output MDU_Out, Busy, HI, LO
    );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// MDU sequencing controller: computes the 64-bit mult/div result at acceptance, holds it while a
// counter models the multi-cycle latency, then commits it to the HI/LO architectural registers.
module mdu_seq_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mdu_seq_ctrl_if.slave mdu,
    output logic          dbg_run
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic               b_zero, accept;

    // Dividing in 64 bits makes 0x80000000 / -1 wrap to 0x80000000 instead of overflowing.
    always_comb begin
        a_sx   = {{32{mdu.A[31]}}, mdu.A};
        b_sx   = {{32{mdu.B[31]}}, mdu.B};
        b_zero = (mdu.B == 32'd0);
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!b_zero) begin
            quot_s = 32'(a_sx / b_sx);
            rem_s  = 32'(a_sx % b_sx);
            quot_u = mdu.A / mdu.B;
            rem_u  = mdu.A % mdu.B;
        end
    end

    assign accept = mdu.Start && !mdu.Req_Cancel && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (mdu.MDU_Op)
                        OP_MULT: begin
                            pend_d  = prod_s;
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = prod_u;
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        // A zero divisor re-commits the current HI/LO so the registers keep their values.
                        OP_DIV: begin
                            pend_d  = b_zero ? {hi_q, lo_q} : {rem_s, quot_s};
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            pend_d  = b_zero ? {hi_q, lo_q} : {rem_u, quot_u};
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = mdu.A;
                        OP_MTLO: lo_d = mdu.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.Busy    = (state_q == RUN);
    assign mdu.HI      = hi_q;
    assign mdu.LO      = lo_q;
    assign mdu.MDU_Out = mdu.MDU_Out_Sel ? lo_q : hi_q;
    assign dbg_run     = (state_q == RUN);

    // The stall unit must never present a new MDU op while one is in flight.
    a_no_start_in_run: assert property (@(posedge clk) disable iff (reset)
        !((state_q == RUN) && mdu.Start));
endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Sequencing controller for the multiply/divide unit (MDU) in the EX stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and holds the HI/LO architectural registers.
- Models the multi-cycle latency with a counter FSM and drives Busy to the hazard/stall unit.
- Supplies the HI/LO read value that feeds the WrRegSel and forwarding muxes as MDU_Out.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  EX-stage instruction is an MDU op; sampled on the rising clk edge.
- MDU_Op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Req_Cancel  input  1  exception/interrupt flush of the EX instruction this cycle.
- MDU_Out_Sel  input  1  0 selects HI, 1 selects LO.
- MDU_Out  output  32  combinational value of HI or LO, per MDU_Out_Sel.
- Busy  output  1  a multi-cycle op is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset is asynchronous and active-high. Reset values: HI=0, LO=0, Busy=0, state=IDLE, counter=0, pending result=0.
- FSM has two states, IDLE and RUN.
- Accept condition: Start=1, Req_Cancel=0, state=IDLE, sampled at edge E.
- IDLE, accepted mult/multu/div/divu:
  - Latch the full 64-bit result into the pending register.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - Busy=1 from the cycle after E.
- IDLE, accepted mthi/mtlo: write A into HI or LO at edge E. State stays IDLE and Busy stays 0.
- IDLE, MDU_Op 0 or 7: no effect.
- RUN: the counter decrements every edge. At the edge where counter==1:
  - commit pending to HI/LO,
  - go to IDLE, so Busy=0 in the following cycle.
- Latency for N cycles: Busy is high for exactly N cycles. The new HI/LO is visible in the first cycle with Busy=0.
- Start while RUN is ignored entirely; the stall unit guarantees it never occurs, and an SVA flags it.
- Req_Cancel with Start in the same cycle: the op is dropped, with no state, counter, HI or LO change.
- Req_Cancel while RUN has no effect. The in-flight op belongs to an older, committed instruction and still completes.
- mult: signed 32x32 product. HI gets bits [63:32], LO gets bits [31:0]. multu is the same with unsigned operands.
- div:
  - signed; quotient truncates toward zero, remainder takes the sign of the dividend.
  - LO gets the quotient, HI gets the remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned, same LO/HI assignment.
- Divide by zero (B=0): the op still takes DIV_CYCLES, Busy behaves normally, and HI/LO stay unchanged at commit.
- Operands are captured at acceptance. Changes on A/B during RUN have no effect.
- MDU_Out = MDU_Out_Sel ? LO : HI, with no register stage. During RUN it shows the pre-op values.
- Reset asserted mid-RUN: the pending result is discarded immediately. Busy=0, HI=LO=0.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MDU_Out shows LO when MDU_Out_Sel=1.
- multu with A=0xFFFFFFFF, B=2 -> after 5 Busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div:
  - A=-7, B=2 -> after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=0 -> 10 Busy cycles, HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> Busy stays 0. HI and LO update on each respective edge.
- Start with Req_Cancel=1 on mult -> Busy stays 0 and HI/LO unchanged. Req_Cancel pulsed during a running div -> div still completes with the correct values.
- reset asserted asynchronously in the 3rd Busy cycle of mult -> Busy, HI and LO go to 0 immediately without waiting for clk. After release, a new mthi is accepted normally.
